// File: rtl/clock_set_ctrl_if.sv
// Set-mode sequencer bus: button/mode/tick inputs and edit controls toward
// the time/date counters and display blanking.
//   tick_1s, sw_mode, btn_settime, btn_inc, btn_dec : toward the sequencer
//   edit_field, edit_active, inc_pulse, dec_pulse, blink_on : from the sequencer
interface clock_set_ctrl_if;

    logic       tick_1s;
    logic       sw_mode;
    logic       btn_settime;
    logic       btn_inc;
    logic       btn_dec;
    logic [1:0] edit_field;
    logic       edit_active;
    logic       inc_pulse;
    logic       dec_pulse;
    logic       blink_on;

    // Side that owns the buttons and consumes the edit controls
    modport master (
        output tick_1s,
        output sw_mode,
        output btn_settime,
        output btn_inc,
        output btn_dec,
        input  edit_field,
        input  edit_active,
        input  inc_pulse,
        input  dec_pulse,
        input  blink_on
    );

    // The sequencer itself
    modport slave (
        input  tick_1s,
        input  sw_mode,
        input  btn_settime,
        input  btn_inc,
        input  btn_dec,
        output edit_field,
        output edit_active,
        output inc_pulse,
        output dec_pulse,
        output blink_on
    );

endinterface

// File: rtl/clock_set_ctrl.sv
// Set-mode sequencer for the clock/calendar datapath.
// Conditions the three raw buttons (sync, debounce, edge detect, auto-repeat),
// walks the field-select FSM and issues single-cycle inc/dec strobes, drives
// the blink enable for the selected field and leaves set mode on inactivity
// timeout or a display-mode change.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : clock_set_ctrl_if.slave (tick_1s, sw_mode, btn_* in;
//             edit_field, edit_active, inc_pulse, dec_pulse, blink_on out)
module clock_set_ctrl #(
    parameter int unsigned DEBOUNCE_CYC   = 1000000,
    parameter int unsigned REPEAT_DLY_CYC = 25000000,
    parameter int unsigned REPEAT_CYC     = 5000000,
    parameter int unsigned BLINK_HALF_CYC = 12500000,
    parameter int unsigned TIMEOUT_S      = 10
) (
    input logic              clk,
    input logic              reset_n,
    clock_set_ctrl_if.slave  bus
);

    localparam int unsigned NBTN    = 3;
    localparam int unsigned BTN_SET = 0;
    localparam int unsigned BTN_INC = 1;
    localparam int unsigned BTN_DEC = 2;

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int unsigned RPT_MAX = (REPEAT_DLY_CYC > REPEAT_CYC) ? REPEAT_DLY_CYC : REPEAT_CYC;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
    localparam int unsigned BL_W    = $clog2(BLINK_HALF_CYC + 1);
    localparam int unsigned TO_W    = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_F1   = 2'd1,
        S_F2   = 2'd2,
        S_F3   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [NBTN-1:0]     raw_c;
    logic [NBTN-1:0]     sync1;
    logic [NBTN-1:0]     sync2;
    logic [NBTN-1:0]     deb;
    logic [NBTN-1:0]     deb_q;
    logic [NBTN-1:0]     press;
    logic [DB_W-1:0]     db_cnt [NBTN];

    // Index 0 = inc, 1 = dec for the repeat machinery
    logic [1:0]          lvl_c;
    logic [1:0]          prs_c;
    logic [1:0]          rpt_armed;
    logic [1:0]          rpt_phase;
    logic [RPT_W-1:0]    rpt_cnt [2];
    logic [1:0]          rpt_fire_c;
    logic                both_c;

    logic [TO_W-1:0]     tcnt;
    logic [TO_W-1:0]     tcnt_next;
    logic                timeout_c;
    logic                mode_chg_c;
    logic                mode_ref;

    logic                hold_c;
    logic                inc_next_c;
    logic                dec_next_c;

    logic                edit_active_q;
    logic                inc_pulse_q;
    logic                dec_pulse_q;
    logic                blink_q;
    logic [BL_W-1:0]     bcnt;

    assign raw_c = {bus.btn_dec, bus.btn_inc, bus.btn_settime};
    assign lvl_c = {deb[BTN_DEC], deb[BTN_INC]};
    assign prs_c = {press[BTN_DEC], press[BTN_INC]};

    // Synchronize, debounce and rising-edge detect each button
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_q <= '0;
            press <= '0;
            for (int unsigned i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw_c;
            sync2 <= sync1;
            deb_q <= deb;
            press <= deb & ~deb_q;
            for (int unsigned i = 0; i < NBTN; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    // Count would reach DEBOUNCE_CYC: accept the new level
                    deb[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Auto-repeat due this cycle; simultaneous inc+dec holds suppress both
    always_comb begin
        both_c     = deb[BTN_INC] & deb[BTN_DEC];
        rpt_fire_c = '0;
        for (int unsigned k = 0; k < 2; k++) begin
            rpt_fire_c[k] = rpt_armed[k] & lvl_c[k] & ~both_c &
                            (rpt_cnt[k] == (rpt_phase[k] ? RPT_W'(REPEAT_CYC - 1)
                                                          : RPT_W'(REPEAT_DLY_CYC - 1)));
        end
    end

    // Inactivity counter and forced-exit conditions
    always_comb begin
        tcnt_next = tcnt;
        if (state == S_IDLE || (|press) || (|rpt_fire_c)) begin
            tcnt_next = '0;
        end else if (bus.tick_1s && (tcnt != TO_W'(TIMEOUT_S))) begin
            tcnt_next = tcnt + TO_W'(1);
        end
        timeout_c  = (state != S_IDLE) && (tcnt_next == TO_W'(TIMEOUT_S));
        mode_chg_c = (state != S_IDLE) && (bus.sw_mode != mode_ref);
    end

    // Field-select state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Field-select next state; forced exits outrank settime
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (press[BTN_SET]) state_next = S_F1;
            S_F1:    if (press[BTN_SET]) state_next = S_F2;
            S_F2:    if (press[BTN_SET]) state_next = S_F3;
            S_F3:    if (press[BTN_SET]) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (timeout_c || mode_chg_c) begin
            state_next = S_IDLE;
        end
    end

    // Strobe requests only while editing a stable field
    always_comb begin
        hold_c     = (state != S_IDLE) && (state_next == state);
        inc_next_c = hold_c && !both_c && (prs_c[0] || rpt_fire_c[0]);
        dec_next_c = hold_c && !both_c && (prs_c[1] || rpt_fire_c[1]) && !inc_next_c;
    end

    // Repeat counters: delay phase after a press, then period phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_armed <= '0;
            rpt_phase <= '0;
            for (int unsigned k = 0; k < 2; k++) begin
                rpt_cnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                if (!hold_c || both_c || !lvl_c[k]) begin
                    rpt_armed[k] <= 1'b0;
                    rpt_phase[k] <= 1'b0;
                    rpt_cnt[k]   <= '0;
                end else if (prs_c[k]) begin
                    rpt_armed[k] <= 1'b1;
                    rpt_phase[k] <= 1'b0;
                    rpt_cnt[k]   <= '0;
                end else if (rpt_fire_c[k]) begin
                    rpt_phase[k] <= 1'b1;
                    rpt_cnt[k]   <= '0;
                end else if (rpt_armed[k]) begin
                    rpt_cnt[k]   <= rpt_cnt[k] + RPT_W'(1);
                end
            end
        end
    end

    // Timeout count and mode snapshot taken on entry to the first field
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tcnt     <= '0;
            mode_ref <= 1'b0;
        end else begin
            tcnt <= tcnt_next;
            if (state == S_IDLE && state_next == S_F1) begin
                mode_ref <= bus.sw_mode;
            end
        end
    end

    // Registered strobes and edit flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edit_active_q <= 1'b0;
            inc_pulse_q   <= 1'b0;
            dec_pulse_q   <= 1'b0;
        end else begin
            edit_active_q <= (state_next != S_IDLE);
            inc_pulse_q   <= inc_next_c;
            dec_pulse_q   <= dec_next_c;
        end
    end

    // Blink: steady in idle, restarted visible on field change or adjustment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_q <= 1'b1;
            bcnt    <= '0;
        end else if (state_next == S_IDLE) begin
            blink_q <= 1'b1;
            bcnt    <= '0;
        end else if ((state_next != state) || inc_next_c || dec_next_c) begin
            blink_q <= 1'b1;
            bcnt    <= '0;
        end else if (bcnt == BL_W'(BLINK_HALF_CYC - 1)) begin
            blink_q <= ~blink_q;
            bcnt    <= '0;
        end else begin
            bcnt    <= bcnt + BL_W'(1);
        end
    end

    assign bus.edit_field  = state;
    assign bus.edit_active = edit_active_q;
    assign bus.inc_pulse   = inc_pulse_q;
    assign bus.dec_pulse   = dec_pulse_q;
    assign bus.blink_on    = blink_q;

endmodule
